rtc_apb_if: RTL and testbench

RTC_APB_IF -- requirements
Module: rtc_apb_if

---
 rtl/rtc_pkg.sv | 34 +++
 rtl/rtc_bcd_check.sv | 19 +
 rtl/rtc_apb_if.sv | 195 +++++++++++++++++++
 tb/tb_rtc_apb_if.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared register map, field layout and widths for the RTC APB
// register interface, plus the BCD byte range helper used by rtc_bcd_check.
package rtc_pkg;

  localparam int TIME_W  = 22;  // BCD hh:mm:ss
  localparam int TIMER_W = 17;
  localparam int INIT_W  = 10;

  // Word offsets, decoded from PADDR[4:2]
  localparam logic [2:0] OFF_CLOCK      = 3'd0;
  localparam logic [2:0] OFF_INIT_SEC   = 3'd1;
  localparam logic [2:0] OFF_ALARM      = 3'd2;
  localparam logic [2:0] OFF_TIMER      = 3'd3;
  localparam logic [2:0] OFF_TIMER_VAL  = 3'd4;
  localparam logic [2:0] OFF_IRQ_STATUS = 3'd5;
  localparam logic [2:0] OFF_IRQ_MASK   = 3'd6;

  // Field bit positions
  localparam int ALARM_EN_BIT     = 31;
  localparam int TIMER_EN_BIT     = 31;
  localparam int TIMER_RETRIG_BIT = 30;
  localparam int IRQ_BIT          = 0;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } apb_state_e;

  // Both BCD digits <= 9 and the byte no larger than max (also BCD)
  function automatic logic bcd_byte_ok(input logic [7:0] b, input logic [7:0] max);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b <= max);
  endfunction

endpackage

// File: rtl/rtc_bcd_check.sv
// rtc_bcd_check: combinational validator for a BCD hh:mm:ss time word.
//   time_i  [21:0] : {hh[5:0], mm[7:0], ss[7:0]}
//   valid_o        : 1 when every digit is decimal and hh<=23, mm<=59, ss<=59
module rtc_bcd_check
  import rtc_pkg::*;
(
  input  logic [TIME_W-1:0] time_i,
  output logic              valid_o
);

  logic [7:0] hh, mm, ss;

  assign hh = {2'b00, time_i[21:16]};
  assign mm = time_i[15:8];
  assign ss = time_i[7:0];

  assign valid_o = bcd_byte_ok(hh, 8'h23) & bcd_byte_ok(mm, 8'h59) & bcd_byte_ok(ss, 8'h59);

endmodule

// File: rtl/rtc_apb_if.sv
// rtc_apb_if: APB slave register block for the RTC core.
//   APB   : PADDR/PWDATA/PWRITE/PSEL/PENABLE in; PRDATA/PREADY/PSLVERR out.
//           Writes complete with no wait state, reads with exactly one.
//   Clock : clock_o/init_sec_cnt_o/clock_update_o out, clock_i live time in.
//   Alarm : alarm_clock_o/alarm_enable_o/alarm_update_o out, alarm_clock_i in.
//   Timer : timer_target_o/enable/retrig/update out, timer_value_i in.
//   IRQ   : event_i pulse sets pending; irq_o = pending & mask (registered).
// Build option: define RTC_BCD_CHECK_EN to reject CLOCK/ALARM writes that are
// not valid BCD times (PSLVERR, no state change, no update pulse).
module rtc_apb_if
  import rtc_pkg::*;
(
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [11:0]        PADDR,
  input  logic [31:0]        PWDATA,
  input  logic               PWRITE,
  input  logic               PSEL,
  input  logic               PENABLE,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  output logic               clock_update_o,
  output logic [TIME_W-1:0]  clock_o,
  output logic [INIT_W-1:0]  init_sec_cnt_o,
  input  logic [TIME_W-1:0]  clock_i,
  output logic               alarm_update_o,
  output logic               alarm_enable_o,
  output logic [TIME_W-1:0]  alarm_clock_o,
  input  logic [TIME_W-1:0]  alarm_clock_i,
  output logic               timer_update_o,
  output logic               timer_enable_o,
  output logic               timer_retrig_o,
  output logic [TIMER_W-1:0] timer_target_o,
  input  logic [TIMER_W-1:0] timer_value_i,
  input  logic               event_i,
  output logic               irq_o
);

  apb_state_e state_q, state_d;

  logic [2:0]  off;
  logic        wr_acc, rd_acc, wr_err, wr_ok;
  logic        clk_ok, alm_ok;
  logic [31:0] rd_mux, rd_data_q;
  logic        rd_bad, rd_err_q;

  logic [TIME_W-1:0]  clock_q, alarm_q;
  logic [INIT_W-1:0]  init_q;
  logic [TIMER_W-1:0] tgt_q;
  logic alarm_en_q, timer_en_q, retrig_q;
  logic clk_upd_q, alm_upd_q, tmr_upd_q;
  logic pending_q, pending_d, mask_q, mask_d, irq_q, w1c;

  logic unused_bits;
  assign unused_bits = ^{PADDR[11:5], PADDR[1:0], PWDATA[29:22]};

  assign off    = PADDR[4:2];
  assign wr_acc = (state_q == ST_IDLE) & PSEL & PENABLE & PWRITE;
  assign rd_acc = (state_q == ST_IDLE) & PSEL & PENABLE & ~PWRITE;

`ifdef RTC_BCD_CHECK_EN
  rtc_bcd_check u_clock_chk (.time_i(PWDATA[TIME_W-1:0]), .valid_o(clk_ok));
  rtc_bcd_check u_alarm_chk (.time_i(PWDATA[TIME_W-1:0]), .valid_o(alm_ok));
`else
  assign clk_ok = 1'b1;
  assign alm_ok = 1'b1;
`endif

  // Unmapped offset, read-only TIMER_VAL, or rejected time write
  assign wr_err = (off == 3'd7) | (off == OFF_TIMER_VAL) |
                  ((off == OFF_CLOCK) & ~clk_ok) | ((off == OFF_ALARM) & ~alm_ok);
  assign wr_ok  = wr_acc & ~wr_err;

  // FSM: next state and APB handshake outputs
  always_comb begin
    state_d = state_q;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    case (state_q)
      ST_IDLE: begin
        PREADY  = ~rd_acc;
        PSLVERR = wr_acc & wr_err;
        if (rd_acc) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Only complete if the master is still there; always leave next cycle
        PREADY  = PSEL & PENABLE;
        PSLVERR = PSEL & PENABLE & rd_err_q;
        PRDATA  = rd_data_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Read mux; live inputs sampled in the first access cycle for coherence
  always_comb begin
    rd_mux = '0;
    rd_bad = 1'b0;
    case (off)
      OFF_CLOCK:      rd_mux[TIME_W-1:0] = clock_i;
      OFF_INIT_SEC:   rd_mux[INIT_W-1:0] = init_q;
      OFF_ALARM: begin
        rd_mux[TIME_W-1:0]   = alarm_clock_i;
        rd_mux[ALARM_EN_BIT] = alarm_en_q;
      end
      OFF_TIMER: begin
        rd_mux[TIMER_W-1:0]      = tgt_q;
        rd_mux[TIMER_RETRIG_BIT] = retrig_q;
        rd_mux[TIMER_EN_BIT]     = timer_en_q;
      end
      OFF_TIMER_VAL:  rd_mux[TIMER_W-1:0] = timer_value_i;
      OFF_IRQ_STATUS: rd_mux[IRQ_BIT]     = pending_q;
      OFF_IRQ_MASK:   rd_mux[IRQ_BIT]     = mask_q;
      default:        rd_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else if (rd_acc) begin
      rd_data_q <= rd_mux;
      rd_err_q  <= rd_bad;
    end
  end

  // IRQ: a new event wins over a simultaneous W1C; irq follows the next state
  // so it rises the cycle after the event.
  assign w1c       = wr_ok & (off == OFF_IRQ_STATUS) & PWDATA[IRQ_BIT];
  assign pending_d = event_i | (pending_q & ~w1c);
  assign mask_d    = (wr_ok & (off == OFF_IRQ_MASK)) ? PWDATA[IRQ_BIT] : mask_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clock_q    <= '0;
      init_q     <= '0;
      alarm_q    <= '0;
      alarm_en_q <= 1'b0;
      tgt_q      <= '0;
      timer_en_q <= 1'b0;
      retrig_q   <= 1'b0;
      clk_upd_q  <= 1'b0;
      alm_upd_q  <= 1'b0;
      tmr_upd_q  <= 1'b0;
      pending_q  <= 1'b0;
      mask_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      clk_upd_q <= wr_ok & (off == OFF_CLOCK);
      alm_upd_q <= wr_ok & (off == OFF_ALARM);
      tmr_upd_q <= wr_ok & (off == OFF_TIMER);
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= pending_d & mask_d;
      if (wr_ok) begin
        case (off)
          OFF_CLOCK:    clock_q <= PWDATA[TIME_W-1:0];
          OFF_INIT_SEC: init_q  <= PWDATA[INIT_W-1:0];
          OFF_ALARM: begin
            alarm_q    <= PWDATA[TIME_W-1:0];
            alarm_en_q <= PWDATA[ALARM_EN_BIT];
          end
          OFF_TIMER: begin
            tgt_q      <= PWDATA[TIMER_W-1:0];
            retrig_q   <= PWDATA[TIMER_RETRIG_BIT];
            timer_en_q <= PWDATA[TIMER_EN_BIT];
          end
          default: ;
        endcase
      end
    end
  end

  assign clock_o        = clock_q;
  assign init_sec_cnt_o = init_q;
  assign clock_update_o = clk_upd_q;
  assign alarm_clock_o  = alarm_q;
  assign alarm_enable_o = alarm_en_q;
  assign alarm_update_o = alm_upd_q;
  assign timer_target_o = tgt_q;
  assign timer_enable_o = timer_en_q;
  assign timer_retrig_o = retrig_q;
  assign timer_update_o = tmr_upd_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_rtc_apb_if.sv
// tb_rtc_apb_if: self-checking bench for rtc_apb_if. Expected read data is
// queued when a read is issued and popped when PREADY completes it.
module tb_rtc_apb_if;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        clock_update_o, alarm_update_o, alarm_enable_o;
  logic        timer_update_o, timer_enable_o, timer_retrig_o, irq_o;
  logic [21:0] clock_o, alarm_clock_o;
  logic [21:0] clock_i = '0, alarm_clock_i = '0;
  logic [9:0]  init_sec_cnt_o;
  logic [16:0] timer_target_o;
  logic [16:0] timer_value_i = '0;
  logic        event_i = 1'b0;

  rtc_apb_if dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .clock_update_o(clock_update_o), .clock_o(clock_o), .init_sec_cnt_o(init_sec_cnt_o),
    .clock_i(clock_i),
    .alarm_update_o(alarm_update_o), .alarm_enable_o(alarm_enable_o),
    .alarm_clock_o(alarm_clock_o), .alarm_clock_i(alarm_clock_i),
    .timer_update_o(timer_update_o), .timer_enable_o(timer_enable_o),
    .timer_retrig_o(timer_retrig_o), .timer_target_o(timer_target_o),
    .timer_value_i(timer_value_i),
    .event_i(event_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        ev_acc = 1'b0;
  logic        werr;
  logic [31:0] wdat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Zero-wait write; returns PSLVERR/PRDATA seen in the completing cycle.
  // Returns #1 after the commit edge, i.e. inside the update-pulse cycle.
  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d,
                        output logic err, output logic [31:0] rdat);
    @(posedge clk_i); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk_i); #1;
    PENABLE = 1'b1; event_i = ev_acc;
    @(negedge clk_i);
    chk("wr_pready", 32'(PREADY), 32'd1);
    err  = PSLVERR;
    rdat = PRDATA;
    @(posedge clk_i); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; event_i = 1'b0;
  endtask

  // Read expecting one wait state; optionally changes clock_i after the
  // first access edge to prove the sampled value is held.
  task automatic apb_rd(input string tag, input logic [11:0] a, input logic [31:0] exp,
                        input logic exp_err, input logic chg, input logic [21:0] chg_val);
    int waits;
    exp_q.push_back(exp);
    @(posedge clk_i); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge clk_i); #1;
    PENABLE = 1'b1;
    waits = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (PREADY) break;
      waits++;
      @(posedge clk_i); #1;
      if (chg) clock_i = chg_val;
    end
    chk({tag, "_waits"}, 32'(waits), 32'd1);
    chk({tag, "_data"}, PRDATA, exp_q.pop_front());
    chk({tag, "_err"}, 32'(PSLVERR), 32'(exp_err));
    @(posedge clk_i); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic chk_upd(input string tag, input logic c, input logic al, input logic t);
    chk({tag, "_cupd"}, 32'(clock_update_o), 32'(c));
    chk({tag, "_aupd"}, 32'(alarm_update_o), 32'(al));
    chk({tag, "_tupd"}, 32'(timer_update_o), 32'(t));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_pready", 32'(PREADY), 32'd1);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_en", 32'({alarm_enable_o, timer_enable_o, timer_retrig_o}), 32'd0);
    chk_upd("rst", 1'b0, 1'b0, 1'b0);
    rstn_i = 1'b1;

    // CLOCK write: pulse for exactly one cycle after the write
    apb_wr(12'h000, 32'h0012_3456, werr, wdat);
    chk("clk_wr_err", 32'(werr), 32'd0);
    chk_upd("clk_wr", 1'b1, 1'b0, 1'b0);
    chk("clk_o", 32'(clock_o), 32'h0012_3456);
    @(posedge clk_i); #1;
    chk_upd("clk_wr2", 1'b0, 1'b0, 1'b0);

    // CLOCK read with live time ticking during the wait state
    clock_i = 22'h23_5959;
    apb_rd("clk_rd", 12'h000, 32'h0023_5959, 1'b0, 1'b1, 22'h00_0000);

    // TIMER write
    apb_wr(12'h00C, 32'hC000_0100, werr, wdat);
    chk("tmr_wr_err", 32'(werr), 32'd0);
    chk_upd("tmr_wr", 1'b0, 1'b0, 1'b1);
    chk("tmr_en", 32'(timer_enable_o), 32'd1);
    chk("tmr_retrig", 32'(timer_retrig_o), 32'd1);
    chk("tmr_tgt", 32'(timer_target_o), 32'h100);
    apb_rd("tmr_rd", 12'h00C, 32'hC000_0100, 1'b0, 1'b0, '0);

    // ALARM write and read (read returns live alarm_clock_i)
    apb_wr(12'h008, 32'h8001_2345, werr, wdat);
    chk_upd("alm_wr", 1'b0, 1'b1, 1'b0);
    chk("alm_o", 32'(alarm_clock_o), 32'h0001_2345);
    chk("alm_en", 32'(alarm_enable_o), 32'd1);
    alarm_clock_i = 22'h11_1111;
    apb_rd("alm_rd", 12'h008, 32'h8011_1111, 1'b0, 1'b0, '0);

    // INIT_SEC: no pulse, unused bits read 0
    apb_wr(12'h004, 32'hFFFF_FFFF, werr, wdat);
    chk_upd("init_wr", 1'b0, 1'b0, 1'b0);
    chk("init_o", 32'(init_sec_cnt_o), 32'h3FF);
    apb_rd("init_rd", 12'h004, 32'h0000_03FF, 1'b0, 1'b0, '0);

    timer_value_i = 17'h1_ABCD;
    apb_rd("tval_rd", 12'h010, 32'h0001_ABCD, 1'b0, 1'b0, '0);

    // IRQ: event, W1C colliding with event, W1C alone
    apb_wr(12'h018, 32'h1, werr, wdat);
    @(posedge clk_i); #1; event_i = 1'b1;
    @(posedge clk_i); #1; event_i = 1'b0;
    chk("irq_set", 32'(irq_o), 32'd1);
    ev_acc = 1'b1;
    apb_wr(12'h014, 32'h1, werr, wdat);
    ev_acc = 1'b0;
    chk("irq_w1c_race", 32'(irq_o), 32'd1);
    apb_rd("pend_race", 12'h014, 32'h1, 1'b0, 1'b0, '0);
    apb_wr(12'h014, 32'h1, werr, wdat);
    chk("irq_w1c", 32'(irq_o), 32'd0);
    apb_rd("pend_clr", 12'h014, 32'h0, 1'b0, 1'b0, '0);
    apb_rd("mask_rd", 12'h018, 32'h1, 1'b0, 1'b0, '0);

    // Unmapped offset and read-only TIMER_VAL
    apb_rd("unmap_rd", 12'h01C, 32'h0, 1'b1, 1'b0, '0);
    apb_wr(12'h01C, 32'hFFFF_FFFF, werr, wdat);
    chk("unmap_wr_err", 32'(werr), 32'd1);
    chk("unmap_wr_data", wdat, 32'd0);
    chk_upd("unmap_wr", 1'b0, 1'b0, 1'b0);
    apb_wr(12'h010, 32'h0000_0000, werr, wdat);
    chk("tval_wr_err", 32'(werr), 32'd1);
    chk("tval_wr_data", wdat, 32'd0);
    chk_upd("tval_wr", 1'b0, 1'b0, 1'b0);
    apb_rd("tmr_keep", 12'h00C, 32'hC000_0100, 1'b0, 1'b0, '0);
    apb_rd("mask_keep", 12'h018, 32'h1, 1'b0, 1'b0, '0);

    // PSEL dropped during the wait state: no stale PREADY
    @(posedge clk_i); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = 12'h000;
    @(posedge clk_i); #1; PENABLE = 1'b1;
    @(posedge clk_i); #1; PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk_i);
    chk("abort_ready", 32'(PREADY), 32'd0);
    @(negedge clk_i);
    chk("abort_idle", 32'(PREADY), 32'd1);

`ifdef RTC_BCD_CHECK_EN
    apb_wr(12'h000, 32'h0024_6000, werr, wdat);
    chk("bcd_err", 32'(werr), 32'd1);
    chk_upd("bcd_wr", 1'b0, 1'b0, 1'b0);
    chk("bcd_keep", 32'(clock_o), 32'h0012_3456);
`endif

    // Reset in the middle of a CLOCK write: nothing committed, no pulse
    @(posedge clk_i); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'h0011_1111;
    @(posedge clk_i); #1; PENABLE = 1'b1;
    #2 rstn_i = 1'b0;
    @(posedge clk_i); #1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge clk_i); rstn_i = 1'b1;
    @(posedge clk_i); #1;
    chk_upd("rst_mid", 1'b0, 1'b0, 1'b0);
    chk("rst_mid_clk", 32'(clock_o), 32'd0);
    chk("rst_mid_mask_irq", 32'(irq_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
